// File: rtl/flag_pulse_scheduler.sv
// flag_pulse_scheduler: source-domain issuer for a single-flag CDC crosser. Queues events
// while the crosser is busy and replays them. Define FLAG_SCHED_STATS_EN to build drop_cnt.
module flag_pulse_scheduler #(
  parameter int CNT_W   = 8,  // pending counter width; saturates at 2^CNT_W-1
  parameter int MIN_GAP = 0   // idle cycles after cdc_busy falls, 0..15
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             clear,
  input  logic             cdc_busy,
  output logic             cdc_flag,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
  localparam logic [3:0]       GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_gap_cnt;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_nxt;
  logic             r_flag;
  logic             r_overflow;
  logic             w_issue;
  logic             w_drop;
  logic             w_pend_sat;
  logic             w_gap_load;
  logic             w_gap_done;

  // Reset asserts asynchronously but is released two edges after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // NOTE: flops use non-blocking (<=) so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_WAIT;
      S_WAIT:  if (!cdc_busy) w_state_nxt = (MIN_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ARM ignores cdc_busy: the crosser has not yet reflected the pulse just sent.
  always_comb begin
    w_pend_sat = (r_pending == PEND_MAX);
    w_issue    = (r_state == S_IDLE) && ((r_pending != '0) || req) && !cdc_busy;
    w_gap_load = (r_state == S_WAIT) && !cdc_busy;
    w_gap_done = (r_state == S_GAP) && (r_gap_cnt == 4'd0);
    w_drop     = req && !w_issue && w_pend_sat;
  end

  // A req that coincides with an issue replaces the event being issued.
  always_comb begin
    w_pending_nxt = r_pending;
    if (req && !w_issue && !w_pend_sat) w_pending_nxt = r_pending + PEND_ONE;
    else if (w_issue && !req)           w_pending_nxt = r_pending - PEND_ONE;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_flag    <= 1'b0;
      r_pending <= '0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_flag    <= w_issue;
      r_pending <= w_pending_nxt;
      if (w_gap_load)                                r_gap_cnt <= GAP_LOAD;
      else if ((r_state == S_GAP) && !w_gap_done)    r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

  // clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)    r_overflow <= 1'b0;
    else if (clear)  r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef FLAG_SCHED_STATS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                                 r_drop_cnt <= 16'h0000;
    else if (clear)                               r_drop_cnt <= 16'h0000;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign cdc_flag = r_flag;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_flag_pulse_scheduler.sv
// Bench for flag_pulse_scheduler: three instances (CNT_W/MIN_GAP = 8/0, 2/0, 8/3), each
// with a 6-cycle crosser busy model, checked against a timing-based reference model.
module tb_flag_pulse_scheduler;

  localparam int NI = 3;
  localparam int RT = 6;

`ifdef FLAG_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk        = 1'b0;
  logic resetn     = 1'b0;
  logic req        = 1'b0;
  logic clear      = 1'b0;
  logic force_busy = 1'b0;

  logic [NI-1:0] flag;
  logic [NI-1:0] busy;
  logic [NI-1:0] ovf;
  logic [7:0]    pend0;
  logic [1:0]    pend1;
  logic [7:0]    pend2;
  logic [15:0]   drop0;
  logic [15:0]   drop1;
  logic [15:0]   drop2;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  flag_pulse_scheduler #(.CNT_W(8), .MIN_GAP(0)) u0 (
    .clk(clk), .resetn(resetn), .req(req), .clear(clear), .cdc_busy(busy[0]),
    .cdc_flag(flag[0]), .pending(pend0), .overflow(ovf[0]), .drop_cnt(drop0));

  flag_pulse_scheduler #(.CNT_W(2), .MIN_GAP(0)) u1 (
    .clk(clk), .resetn(resetn), .req(req), .clear(clear), .cdc_busy(busy[1]),
    .cdc_flag(flag[1]), .pending(pend1), .overflow(ovf[1]), .drop_cnt(drop1));

  flag_pulse_scheduler #(.CNT_W(8), .MIN_GAP(3)) u2 (
    .clk(clk), .resetn(resetn), .req(req), .clear(clear), .cdc_busy(busy[2]),
    .cdc_flag(flag[2]), .pending(pend2), .overflow(ovf[2]), .drop_cnt(drop2));

  // Crosser model: busy for RT cycles after it samples a flag pulse; not reset by resetn.
  int bcnt [NI] = '{default: 0};

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (flag[k])           bcnt[k] <= RT;
      else if (bcnt[k] != 0) bcnt[k] <= bcnt[k] - 1;
    end
  end

  assign busy[0] = (bcnt[0] != 0) || force_busy;
  assign busy[1] = (bcnt[1] != 0) || force_busy;
  assign busy[2] = (bcnt[2] != 0) || force_busy;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] want);
    cmp_cnt++;
    if (act !== want) begin
      bad_cnt++;
      $display("FAIL %s u%0d: got %0d expected %0d (t=%0t)", name, k, act, want, $time);
    end
  endtask

  function automatic logic [31:0] dut_pend(input int k);
    case (k)
      0:       return 32'(pend0);
      1:       return 32'(pend1);
      default: return 32'(pend2);
    endcase
  endfunction

  function automatic logic [31:0] dut_drop(input int k);
    case (k)
      0:       return 32'(drop0);
      1:       return 32'(drop1);
      default: return 32'(drop2);
    endcase
  endfunction

  // Reference model: issue eligibility tracked as cycle times rather than states.
  int     pmax  [NI] = '{255, 3, 255};
  int     gap   [NI] = '{0, 0, 3};
  int     m_pend[NI];
  int     m_drop[NI];
  bit     m_ovf [NI];
  bit     m_flag[NI];
  bit     m_wait[NI];
  longint m_from[NI];
  longint m_ok  [NI];
  longint cyc = 0;
  bit     m_issue;
  bit     m_dropev;

  // At each falling edge: compare against the model, then predict the next rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NI; k++) begin
        m_pend[k] = 0; m_drop[k] = 0; m_ovf[k] = 0; m_flag[k] = 0;
        m_wait[k] = 0; m_from[k] = 0; m_ok[k]  = 0;
      end
    end
    for (int k = 0; k < NI; k++) begin
      check("flag",     k, 32'(flag[k]), 32'(m_flag[k]));
      check("pending",  k, dut_pend(k),  32'(m_pend[k]));
      check("overflow", k, 32'(ovf[k]),  32'(m_ovf[k]));
      check("drop_cnt", k, dut_drop(k),  STATS ? 32'(m_drop[k]) : 32'd0);
    end
    if (resetn) begin
      for (int k = 0; k < NI; k++) begin
        if (m_wait[k] && (cyc >= m_from[k]) && !busy[k]) begin
          m_wait[k] = 0;
          m_ok[k]   = cyc + 1 + gap[k];
        end
        m_issue  = !m_wait[k] && (cyc >= m_ok[k]) && ((m_pend[k] != 0) || req) && !busy[k];
        m_dropev = 0;
        if (req && !m_issue) begin
          if (m_pend[k] < pmax[k]) m_pend[k]++;
          else                     m_dropev = 1;
        end else if (m_issue && !req) begin
          m_pend[k]--;
        end
        if (clear) begin
          m_ovf[k]  = 0;
          m_drop[k] = 0;
        end else if (m_dropev) begin
          m_ovf[k] = 1;
          if (m_drop[k] < 65535) m_drop[k]++;
        end
        m_flag[k] = m_issue;
        if (m_issue) begin
          m_wait[k] = 1;
          m_from[k] = cyc + 2;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;
  int tcyc;
  int last_fall [NI];
  int last_delta[NI];
  bit prev_busy [NI];

  initial begin
    repeat (3) tick();
    check("rst_flag",     0, 32'(flag[0]), 32'd0);
    check("rst_pending",  0, 32'(pend0),   32'd0);
    check("rst_overflow", 0, 32'(ovf[0]),  32'd0);
    check("rst_drop",     0, 32'(drop0),   32'd0);
    resetn = 1'b1;
    repeat (5) tick();

    // Single request: pulse in the next cycle, exactly one cycle wide.
    req = 1'b1;
    tick();
    req = 1'b0;
    check("single_flag_hi", 0, 32'(flag[0]), 32'd1);
    check("single_pending", 0, 32'(pend0),   32'd0);
    tick();
    check("single_flag_lo", 0, 32'(flag[0]), 32'd0);
    repeat (15) tick();

    // Burst of 5: first consumed directly, 4 queued, then replayed one by one.
    req = 1'b1;
    repeat (5) tick();
    req = 1'b0;
    check("burst_pending",   0, 32'(pend0),  32'd4);
    check("burst_pending",   2, 32'(pend2),  32'd4);
    check("burst_sat_pend",  1, 32'(pend1),  32'd3);
    check("burst_sat_ovf",   1, 32'(ovf[1]), 32'd1);
    n = 0;
    repeat (80) begin
      tick();
      if (flag[0]) n++;
    end
    check("burst_pulses",    0, 32'(n),     32'd4);
    check("burst_drained",   0, 32'(pend0), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Saturation of the 2-bit counter while the crosser is held busy.
    force_busy = 1'b1;
    req = 1'b1;
    repeat (6) tick();
    req = 1'b0;
    check("sat_pending",  1, 32'(pend1),  32'd3);
    check("sat_overflow", 1, 32'(ovf[1]), 32'd1);
    check("sat_drop",     1, 32'(drop1),  STATS ? 32'd3 : 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_overflow", 1, 32'(ovf[1]), 32'd0);
    check("clr_drop",     1, 32'(drop1),  32'd0);
    check("clr_pending",  1, 32'(pend1),  32'd3);

    // Drain the queue and measure busy-fall to next-flag spacing.
    force_busy = 1'b0;
    tcyc = 0;
    for (int k = 0; k < NI; k++) begin
      prev_busy[k]  = 1'b1;
      last_fall[k]  = 0;
      last_delta[k] = 0;
    end
    repeat (120) begin
      tick();
      tcyc++;
      for (int k = 0; k < NI; k++) begin
        if (prev_busy[k] && !busy[k]) last_fall[k]  = tcyc;
        if (flag[k])                  last_delta[k] = tcyc - last_fall[k];
        prev_busy[k] = busy[k];
      end
    end
    check("gap0_spacing", 0, 32'(last_delta[0]), 32'd2);
    check("gap3_spacing", 2, 32'(last_delta[2]), 32'd5);
    check("drain_pend",   2, 32'(pend2),         32'd0);

    // req and issue in the same IDLE cycle with pending=2.
    force_busy = 1'b1;
    req = 1'b1;
    repeat (2) tick();
    req = 1'b0;
    check("hold_pending", 0, 32'(pend0), 32'd2);
    force_busy = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("same_cyc_pend", 0, 32'(pend0),   32'd2);
    check("same_cyc_flag", 0, 32'(flag[0]), 32'd1);
    check("same_cyc_pend", 1, 32'(pend1),   32'd2);
    repeat (60) tick();

    // Reset during ARM with pending=5.
    force_busy = 1'b1;
    req = 1'b1;
    repeat (5) tick();
    force_busy = 1'b0;
    tick();
    req = 1'b0;
    check("arm_pending", 0, 32'(pend0),   32'd5);
    check("arm_flag",    0, 32'(flag[0]), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("kill_flag",     0, 32'(flag[0]), 32'd0);
    check("kill_pending",  0, 32'(pend0),   32'd0);
    check("kill_overflow", 1, 32'(ovf[1]),  32'd0);
    check("kill_drop",     1, 32'(drop1),   32'd0);
    tick();
    resetn = 1'b1;
    n = 0;
    repeat (12) begin
      tick();
      if (flag[0]) n++;
    end
    check("post_rst_quiet", 0, 32'(n), 32'd0);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("post_rst_req", 0, 32'(flag[0]), 32'd1);
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
